tdc_uart_streamer: RTL
======================

Name: tdc_uart_streamer

Overview:
- Readout-stage consumer of the TDC timestamp FIFO.
- After a start pulse, pops 32-bit TDC words from the FIFO until it is empty. Serialises each word as bytes over a UART 8N1 link, with CTS flow control towards the host.
- Sits between the TDC data FIFO read port and the board TX/CTS/RTS pins. Runs in the single system clock domain (200 MHz, 5 ns period).

Parameters:
- CLK_FREQ_HZ, 200_000_000, system clock frequency.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division, must be >= 4).
- WORD_W, 32, FIFO word width. Must be a multiple of 8. NBYTES = WORD_W/8.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a readout run.
- fifo_empty, input, 1, FIFO empty flag (standard FIFO, not FWFT).
- fifo_rd_en, output, 1, FIFO read strobe; data is valid the cycle after.
- fifo_dout, input, WORD_W, FIFO read data.
- cts_n, input, 1, host clear-to-send, active low; asynchronous pin.
- tx, output, 1, UART serial out; idle high.
- rts_n, output, 1, request-to-send, active low.
- busy, output, 1, high while a run is in progress.
- done, output, 1, one-cycle pulse at end of run.
- word_cnt, output, 16, words sent in current/last run.

Behaviour:
- Reset values: tx=1, rts_n=1, fifo_rd_en=0, busy=0, done=0, word_cnt=0, FSM=IDLE, baud counter=0, CTS synchroniser=2'b11.
- rts_n: driven 0 from the first clk edge after reset release onward.
- cts_n: passed through a 2-flop synchroniser before use. cts_ok = synchronised cts_n == 0.
- FSM states and transitions:
  - IDLE: on start=1 → FETCH; word_cnt cleared, busy=1 from the next cycle. start is ignored in all other states.
  - FETCH: if fifo_empty=1 → FINISH. Else fifo_rd_en=1 for exactly one cycle → LOAD.
  - LOAD: capture fifo_dout into shift word, byte index=0, word_cnt+1 (saturating at 16'hFFFF) → WAIT_CTS.
  - WAIT_CTS: tx held 1. When cts_ok → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. Current byte = word bits [WORD_W-1-8*idx -: 8], i.e. MSB byte first.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then if idx < NBYTES-1: idx+1 → WAIT_CTS; else → FETCH.
  - FINISH: done=1 for one cycle, busy=0 → IDLE.
- CTS is checked only at byte boundaries (WAIT_CTS). Deassertion mid-byte never truncates a frame.
- Timing: byte frame = 10*CLKS_PER_BIT cycles. With CTS continuously asserted there are exactly 2 cycles between successive frames of the same word (STOP→WAIT_CTS→START). Between words there are 4 cycles (FETCH, LOAD, WAIT_CTS, plus STOP exit).
- Empty boundaries:
  - fifo_empty sampled only in FETCH. If empty at the first FETCH: zero-word run, done pulses 2 cycles after start, word_cnt=0.
  - A word written to the FIFO while a byte is on the wire is sent in the same run.
- fifo_rd_en is never asserted while fifo_empty=1. At most one read per word.
- rst_n low at any time, including mid-frame: immediate return to reset values, tx=1 asynchronously. The partially sent word is lost; no FIFO read is re-issued.

Test Plan:
- Sim params CLK_FREQ_HZ=200_000_000, BAUD=12_500_000 (16 clk/bit), cts_n=0. FIFO holds 32'hA1B2C3D4; pulse start → tx carries 0xA1,0xB2,0xC3,0xD4 in that order. Each frame is 160 cycles, LSB first, stop bit high. One fifo_rd_en pulse; done after the second FETCH sees empty; word_cnt=1.
- FIFO empty, pulse start → no tx activity, fifo_rd_en never high, done pulses exactly 2 cycles after start, word_cnt=0, busy high for exactly those cycles.
- FIFO holds 32 words 0..31 → 128 frames decoded by the bench UART receiver match in order, with no framing errors. Exactly 32 fifo_rd_en pulses; word_cnt=32.
- Drive cts_n=1 during frame 2 of word 0x11223344 → byte 0x22 completes intact. tx stays high until cts_n=0 plus 2 synchroniser cycles plus 1, then 0x33 starts.
- Assert rst_n=0 in the middle of DATA of byte 2 → tx=1 with no clock edge, busy=0, word_cnt=0. After release, a new start sends the next FIFO word from its MSB byte.
- Pulse start again while busy=1 → ignored: no extra fifo_rd_en, word order and word_cnt unchanged.

Source files
------------

// File: rtl/tdc_uart_streamer_if.sv
// FIFO read-port bundle between the TDC timestamp FIFO and its UART readout consumer.
// The master side is the consumer: it issues read strobes and samples data and empty.
interface tdc_uart_streamer_if #(
    parameter int unsigned WORD_W = 32
) ();

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_dout;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );

endinterface

// File: rtl/tdc_uart_streamer.sv
// Drains the TDC timestamp FIFO after a start pulse and sends each word as NBYTES UART 8N1
// frames, MSB byte first, LSB bit first. The host's CTS is honoured only between bytes.
module tdc_uart_streamer #(
    parameter int unsigned CLK_FREQ_HZ = 200_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned WORD_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    tdc_uart_streamer_if.master fifo,
    input  logic                cts_n,
    output logic                tx,
    output logic                rts_n,
    output logic                busy,
    output logic                done,
    output logic [15:0]         word_cnt
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned NBYTES       = WORD_W / 8;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IdxW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    // STOP holds one cycle past the stop bit; that is the exit cycle of the inter-frame gap.
    localparam logic [CntW-1:0] StopLast = CntW'(CLKS_PER_BIT);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NBYTES - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("CLK_FREQ_HZ/BAUD must be at least 4");
    end
    if ((WORD_W % 8) != 0 || WORD_W == 0) begin : g_bad_width
        $error("WORD_W must be a non-zero multiple of 8");
    end

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWaitCts,
        StStart,
        StData,
        StStop,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              tx_q, tx_d;
    logic              rts_q;
    logic              cts_meta_q, cts_sync_q;
    logic              rd_en;
    logic              cts_ok;
    logic [7:0]        byte_d;

    assign cts_ok          = ~cts_sync_q;
    assign fifo.fifo_rd_en = rd_en;
    assign tx              = tx_q;
    assign rts_n           = rts_q;
    assign busy            = busy_q;
    assign done            = (state_q == StFinish);
    assign word_cnt        = word_cnt_q;

    // Two-flop synchroniser for the asynchronous CTS pin; idles deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // RTS asserts from the first edge after reset release and stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_q <= 1'b1;
        end else begin
            rts_q <= 1'b0;
        end
    end

    // State and datapath registers; tx is registered so the pin never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state logic, FIFO strobe, and the next tx level derived from the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        busy_d     = busy_q;
        rd_en      = 1'b0;
        tx_d       = 1'b1;
        byte_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFetch;
                    word_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            StFetch: begin
                if (fifo.fifo_empty) begin
                    state_d = StFinish;
                end else begin
                    rd_en   = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                word_d  = fifo.fifo_dout;
                idx_d   = '0;
                state_d = StWaitCts;
                if (word_cnt_q != 16'hFFFF) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            StWaitCts: begin
                if (cts_ok) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == StopLast) begin
                    cnt_d = '0;
                    if (idx_q < IdxLast) begin
                        idx_d   = idx_q + 1'b1;
                        // Shift the next byte into the top position.
                        word_d  = word_q << 8;
                        state_d = StWaitCts;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        byte_d = word_d[WORD_W-1 -: 8];
        if (state_d == StStart) begin
            tx_d = 1'b0;
        end else if (state_d == StData) begin
            tx_d = byte_d[bit_d];
        end
    end

endmodule
